// File: rtl/icycle_ctrl.sv
// icycle_ctrl: instruction-cycle sequencer FETCH->DECODE->EXEC->MEM->WB with memory handshake, retire counter and HALT/timeout traps
//   Optional feature macro: ICYCLE_STEP_EN (adds i_step_mode; when 1, each retire returns to IDLE)
//   Ports:
//     i_clk        system clock, all state on rising edge
//     i_reset      synchronous active-low reset
//     i_run        start/continue execution, sampled in IDLE
//     i_step_mode  (ICYCLE_STEP_EN only) single-step after each retired instruction
//     i_opcode     opcode from IR, valid from DECODE onward
//     i_mem_ack    memory completes the current request this cycle
//     o_mem_req    memory request (FETCH, MEM)
//     o_mem_we     write strobe (MEM, STORE)
//     o_addr_sel   0 = PC drives address, 1 = ALU result drives address
//     o_ir_ld      load IR (FETCH with ack)
//     o_pc_inc     PC+1 (FETCH with ack)
//     o_pc_ld      PC <- jump target (EXEC, JMP)
//     o_reg_we     register file write (WB)
//     o_state      current state encoding
//     o_icycle     retired-instruction count, wraps
//     o_halted     high in HALT or ERR
//     o_err        high in ERR (memory timeout)
module icycle_ctrl #(
    parameter int OPW         = 4,
    parameter int CYCW        = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_run,
`ifdef ICYCLE_STEP_EN
    input  logic            i_step_mode,
`endif
    input  logic [OPW-1:0]  i_opcode,
    input  logic            i_mem_ack,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic            o_addr_sel,
    output logic            o_ir_ld,
    output logic            o_pc_inc,
    output logic            o_pc_ld,
    output logic            o_reg_we,
    output logic [2:0]      o_state,
    output logic [CYCW-1:0] o_icycle,
    output logic            o_halted,
    output logic            o_err
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(4'h8);
    localparam logic [OPW-1:0] OP_STORE = OPW'(4'h9);
    localparam logic [OPW-1:0] OP_JMP   = OPW'(4'hA);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(4'hF);
    localparam int WW = $clog2(MEM_TIMEOUT + 2);
    // r_wait holds the no-ack cycles already seen; the cycle that would be the
    // MEM_TIMEOUT-th one traps unless ack arrives in it
    localparam logic [WW-1:0] TO_LAST = WW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
    state_t          r_state, w_next;
    logic [OPW-1:0]  r_op;
    logic [CYCW-1:0] r_icycle;
    logic [WW-1:0]   r_wait;
    logic            w_step, w_retire, w_waiting, w_timeout;
    logic            w_load, w_store, w_jmp;
    state_t          w_retire_dst;
`ifdef ICYCLE_STEP_EN
    assign w_step = i_step_mode;
`else
    assign w_step = 1'b0;
`endif
    assign w_load       = r_op == OP_LOAD;
    assign w_store      = r_op == OP_STORE;
    assign w_jmp        = r_op == OP_JMP;
    assign w_retire_dst = w_step ? S_IDLE : S_FETCH;
    assign w_waiting    = (r_state == S_FETCH || r_state == S_MEM) && !i_mem_ack;
    assign w_timeout    = (MEM_TIMEOUT != 0) && w_waiting && r_wait == TO_LAST;
    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        o_mem_req  = 1'b0;
        o_mem_we   = 1'b0;
        o_addr_sel = 1'b0;
        o_ir_ld    = 1'b0;
        o_pc_inc   = 1'b0;
        o_pc_ld    = 1'b0;
        o_reg_we   = 1'b0;
        o_halted   = 1'b0;
        o_err      = 1'b0;
        case (r_state)
            S_IDLE:   w_next = i_run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                o_mem_req = 1'b1;
                o_ir_ld   = i_mem_ack;
                o_pc_inc  = i_mem_ack;
                w_next    = i_mem_ack ? S_DECODE : (w_timeout ? S_ERR : S_FETCH);
            end
            // HALT is classified from the live opcode; later states use the latch
            S_DECODE: w_next = (i_opcode == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                o_pc_ld  = w_jmp;
                w_retire = w_jmp;
                w_next   = w_jmp ? w_retire_dst : ((w_load || w_store) ? S_MEM : S_WB);
            end
            S_MEM: begin
                o_mem_req  = 1'b1;
                o_addr_sel = 1'b1;
                o_mem_we   = w_store;
                w_retire   = i_mem_ack && w_store;
                w_next     = i_mem_ack ? (w_store ? w_retire_dst : S_WB) : (w_timeout ? S_ERR : S_MEM);
            end
            S_WB: begin
                o_reg_we = 1'b1;
                w_retire = 1'b1;
                w_next   = w_retire_dst;
            end
            S_HALT:   o_halted = 1'b1;
            S_ERR: begin
                o_halted = 1'b1;
                o_err    = 1'b1;
            end
            default:  w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_icycle <= '0;
            r_wait   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_op <= i_opcode;
            if (w_retire)
                r_icycle <= r_icycle + 1'b1;
            // any cycle that is not a continuing wait (incl. entry to FETCH/MEM) clears the count
            r_wait <= (w_waiting && !w_timeout) ? r_wait + 1'b1 : '0;
        end
    end
    assign o_state  = r_state;
    assign o_icycle = r_icycle;
endmodule
